// File: rtl/array_rf_arbiter_if.sv
// Request/response bundle between two requesters and the shared
// register-file arbiter.
interface array_rf_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             req    [1:0];
  logic             we     [1:0];
  logic [AW-1:0]    addr   [1:0];
  logic [WIDTH-1:0] wdata  [1:0];
  logic             gnt    [1:0];
  logic             rvalid [1:0];
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/array_rf_arbiter.sv
// Two-requester round-robin arbiter in front of a small register file
// with a registered, shared read-data port.
module array_rf_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  array_rf_arbiter_if.slave bus,
  output logic [WIDTH-1:0] mem_o [DEPTH-1:0]
);

  logic [WIDTH-1:0] mem [DEPTH-1:0];
  logic             last;
  logic             g_any;
  logic             g_idx;
  logic             we_sel;
  logic [AW-1:0]    addr_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic             rv0;
  logic             rv1;
  logic [WIDTH-1:0] rdata_q;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    g_any = 1'b0;
    g_idx = 1'b0;
    if (!rst) begin
      unique case ({bus.req[1], bus.req[0]})
        2'b11: begin
          g_any = 1'b1;
          g_idx = ~last;
        end
        2'b01: begin
          g_any = 1'b1;
          g_idx = 1'b0;
        end
        2'b10: begin
          g_any = 1'b1;
          g_idx = 1'b1;
        end
        default: begin
          g_any = 1'b0;
          g_idx = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    we_sel    = bus.we[g_idx];
    addr_sel  = bus.addr[g_idx];
    wdata_sel = bus.wdata[g_idx];
  end

  assign bus.gnt[0] = g_any & ~g_idx;
  assign bus.gnt[1] = g_any &  g_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      last    <= 1'b1;
      rdata_q <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
    end else begin
      rv0 <= g_any & ~we_sel & ~g_idx;
      rv1 <= g_any & ~we_sel &  g_idx;
      if (g_any) begin
        last <= g_idx;
        if (we_sel) begin
          mem[addr_sel] <= wdata_sel;
        end else begin
          rdata_q <= mem[addr_sel];
        end
      end
    end
  end

  assign bus.rvalid[0] = rv0;
  assign bus.rvalid[1] = rv1;
  assign bus.rdata     = rdata_q;
  assign mem_o         = mem;

endmodule

// File: tb/tb_array_rf_arbiter.sv
// Directed bench for array_rf_arbiter: reset, grants, round-robin,
// read-after-write, mid-stream reset and streaming reads.
module tb_array_rf_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] mem_o [3:0];
  int         n_chk;
  int         n_pass;

  array_rf_arbiter_if #(.WIDTH(8), .AW(2)) bus ();

  array_rf_arbiter #(.DEPTH(4), .WIDTH(8), .AW(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .mem_o (mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req[0] = 1'b0;
    bus.req[1] = 1'b0;
    bus.we[0]  = 1'b0;
    bus.we[1]  = 1'b0;
  endtask

  task automatic drive(input int r, input logic w,
                       input logic [1:0] a, input logic [7:0] d);
    bus.req[r]   = 1'b1;
    bus.we[r]    = w;
    bus.addr[r]  = a;
    bus.wdata[r] = d;
  endtask

  task automatic check_mem_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check(tag, {24'd0, mem_o[i]}, 32'd0);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle();
    bus.addr[0]  = '0;
    bus.addr[1]  = '0;
    bus.wdata[0] = '0;
    bus.wdata[1] = '0;
    tick();
    tick();
    check_mem_zero("rst_mem");
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_rv0", bus.rvalid[0], 32'd0);
    check("rst_rv1", bus.rvalid[1], 32'd0);
    check("rst_gnt0", bus.gnt[0], 32'd0);
    check("rst_gnt1", bus.gnt[1], 32'd0);
    // request during reset must not be granted
    drive(0, 1'b1, 2'd3, 8'hEE);
    #1;
    check("rst_req_gnt0", bus.gnt[0], 32'd0);
    tick();
    check("rst_no_wr", {24'd0, mem_o[3]}, 32'd0);
    idle();
    rst = 1'b0;

    // single write then read
    drive(0, 1'b1, 2'd2, 8'hA5);
    #1;
    check("wr_gnt0", bus.gnt[0], 32'd1);
    check("wr_gnt1", bus.gnt[1], 32'd0);
    tick();
    check("wr_mem2", {24'd0, mem_o[2]}, 32'h A5);
    check("wr_mem0", {24'd0, mem_o[0]}, 32'd0);
    check("wr_rv0", bus.rvalid[0], 32'd0);
    drive(0, 1'b0, 2'd2, 8'h00);
    #1;
    check("rd_gnt0", bus.gnt[0], 32'd1);
    tick();
    check("rd_rv0", bus.rvalid[0], 32'd1);
    check("rd_rv1", bus.rvalid[1], 32'd0);
    check("rd_rdata", bus.rdata, 32'h A5);
    idle();

    // contention fairness right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 2'd0, 8'h00);
      drive(1, 1'b0, 2'd0, 8'h00);
      #1;
      check("rr_gnt0", bus.gnt[0], (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_gnt1", bus.gnt[1], (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("rr_rv0", bus.rvalid[0], (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_rv1", bus.rvalid[1], (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    check("rr_rdata", bus.rdata, 32'd0);
    idle();

    // simultaneous write (0) and read (1) of the same entry
    drive(0, 1'b1, 2'd1, 8'h3C);
    drive(1, 1'b0, 2'd1, 8'h00);
    #1;
    check("sim_gnt0", bus.gnt[0], 32'd1);
    check("sim_gnt1", bus.gnt[1], 32'd0);
    tick();
    bus.req[0] = 1'b0;
    #1;
    check("sim2_gnt1", bus.gnt[1], 32'd1);
    check("sim2_gnt0", bus.gnt[0], 32'd0);
    tick();
    check("sim_rdata", bus.rdata, 32'h 3C);
    check("sim_rv1", bus.rvalid[1], 32'd1);
    check("sim_rv0", bus.rvalid[0], 32'd0);
    idle();

    // idle cycle clears rvalid, holds rdata
    #1;
    check("idle_gnt0", bus.gnt[0], 32'd0);
    check("idle_gnt1", bus.gnt[1], 32'd0);
    tick();
    check("idle_rv1", bus.rvalid[1], 32'd0);
    check("idle_rdata", bus.rdata, 32'h 3C);

    // fill then stream reads from requester 1
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, k[1:0], 8'h10 + k[7:0]);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b0, k[1:0], 8'h00);
      #1;
      check("st_gnt1", bus.gnt[1], 32'd1);
      tick();
      check("st_rdata", bus.rdata, 32'h10 + k);
      check("st_rv1", bus.rvalid[1], 32'd1);
    end
    idle();

    // reset while a read is granted
    drive(1, 1'b0, 2'd2, 8'h00);
    #1;
    check("mr_gnt1", bus.gnt[1], 32'd1);
    rst = 1'b1;
    #1;
    check("mr_gnt1_rst", bus.gnt[1], 32'd0);
    tick();
    check("mr_rv0", bus.rvalid[0], 32'd0);
    check("mr_rv1", bus.rvalid[1], 32'd0);
    check("mr_rdata", bus.rdata, 32'd0);
    check_mem_zero("mr_mem");
    rst = 1'b0;
    #1;
    check("mr_regnt1", bus.gnt[1], 32'd1);
    tick();
    check("mr_re_rv1", bus.rvalid[1], 32'd1);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
